// File: rtl/cmin_sched_pkg.sv
// Shared types and helpers for the Q-buffer scheduler.
package cmin_sched_pkg;

  localparam int QW = 16 * 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_STREAM
  } state_t;

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
    return (len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/cmin_q_prefetch.sv
// One-entry holding buffer between the Q-buffer read port and the output word register.
import cmin_sched_pkg::*;

module cmin_q_prefetch #(
  parameter int W = QW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         drain,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else begin
      if (flush)      valid <= 1'b0;
      else if (load)  valid <= 1'b1;
      else if (drain) valid <= 1'b0;
      if (load && !flush) dout <= din;
    end
  end

endmodule

// File: rtl/cmin_q_scheduler.sv
// Streams cfg_q_len query words cfg_passes times from the Q buffer into the bit-serial
// compute-input stage, with a one-entry prefetch so words follow updates without bubbles.
//
// state    | meaning
// S_IDLE   | waiting for start; outputs quiet
// S_FILL   | first read issued, waiting for word 0 to reach data_out
// S_STREAM | presenting words, advancing on data_out_update
import cmin_sched_pkg::*;

module cmin_q_scheduler #(
  parameter int MACRO_DATA_WIDTH = 16,
  parameter int COMPUTE_CYCLE    = 8,
  parameter int Q_BUF_ADDR_WIDTH = 2,
  parameter int PASS_CNT_WIDTH   = 8
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  input  logic                                      abort,
  input  logic [Q_BUF_ADDR_WIDTH:0]                 cfg_q_len,
  input  logic [PASS_CNT_WIDTH-1:0]                 cfg_passes,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      err_update,
  output logic                                      q_rd_en,
  output logic [Q_BUF_ADDR_WIDTH-1:0]               q_rd_addr,
  input  logic [MACRO_DATA_WIDTH*COMPUTE_CYCLE-1:0] q_rd_data,
  output logic [MACRO_DATA_WIDTH*COMPUTE_CYCLE-1:0] data_out,
  output logic                                      data_out_vld,
  input  logic                                      data_out_rdy,
  input  logic                                      data_out_update
);

  localparam int DW = MACRO_DATA_WIDTH * COMPUTE_CYCLE;
  localparam int LW = Q_BUF_ADDR_WIDTH + 1;
  localparam int CW = Q_BUF_ADDR_WIDTH + PASS_CNT_WIDTH + 1;
  localparam int unsigned QD = 2 ** Q_BUF_ADDR_WIDTH;

  state_t                      state, state_nx;
  logic [LW-1:0]               len_q, len_c;
  logic [PASS_CNT_WIDTH-1:0]   passes_q, pass_cnt;
  logic [Q_BUF_ADDR_WIDTH-1:0] rd_addr;
  logic [CW-1:0]               issue_rem, cons_rem, total;
  logic                        rd_pend, vld, done_q, err_q;
  logic [DW-1:0]               dout_q, pf_dout;
  logic                        pf_vld, pf_load, pf_drain;
  logic                        start_ok, zero_cfg, consume, last, issue, to_out;
  logic [1:0]                  occ;
  logic                        unused_rdy;

  // Word advance is driven solely by data_out_update.
  assign unused_rdy = data_out_rdy;

  always_comb begin
    start_ok = (state == S_IDLE) && start && !abort;
    len_c    = LW'(clamp_len(32'(cfg_q_len), QD));
    zero_cfg = (len_c == '0) || (cfg_passes == '0);
    total    = CW'(len_c) * CW'(cfg_passes);
    consume  = data_out_update && vld && !abort;
    last     = consume && (cons_rem == CW'(1));
    // Words held or arriving after this cycle; a new read must have a slot to land in.
    occ      = 2'(vld) + 2'(pf_vld) + 2'(rd_pend) - 2'(consume);
    issue    = (state != S_IDLE) && !abort && (issue_rem != '0) &&
               (pass_cnt < passes_q) && (occ < 2'd2);
    to_out   = rd_pend && (!vld || (consume && !pf_vld));
    pf_load  = rd_pend && !to_out && !abort;
    pf_drain = consume && pf_vld;
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start_ok && !zero_cfg) state_nx = S_FILL;
        S_FILL:   if (to_out) state_nx = S_STREAM;
        S_STREAM: if (last) state_nx = S_IDLE;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      len_q     <= '0;
      passes_q  <= '0;
      pass_cnt  <= '0;
      rd_addr   <= '0;
      issue_rem <= '0;
      cons_rem  <= '0;
      rd_pend   <= 1'b0;
      vld       <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      dout_q    <= '0;
    end else begin
      state  <= state_nx;
      done_q <= (start_ok && zero_cfg) || last;
      if (start_ok)                     err_q <= 1'b0;
      else if (data_out_update && !vld) err_q <= 1'b1;

      if (start_ok) begin
        len_q     <= len_c;
        passes_q  <= cfg_passes;
        pass_cnt  <= '0;
        rd_addr   <= '0;
        issue_rem <= total;
        cons_rem  <= total;
      end else begin
        if (issue) begin
          issue_rem <= issue_rem - CW'(1);
          if ({1'b0, rd_addr} == len_q - LW'(1)) begin
            rd_addr  <= '0;
            pass_cnt <= pass_cnt + PASS_CNT_WIDTH'(1);
          end else begin
            rd_addr <= rd_addr + Q_BUF_ADDR_WIDTH'(1);
          end
        end
        if (consume) cons_rem <= cons_rem - CW'(1);
      end

      if (abort) begin
        rd_pend <= 1'b0;
        vld     <= 1'b0;
      end else begin
        rd_pend <= issue;
        vld     <= (vld && !consume) || pf_drain || to_out;
        if (pf_drain)    dout_q <= pf_dout;
        else if (to_out) dout_q <= q_rd_data;
      end
    end
  end

  cmin_q_prefetch #(.W(DW)) u_prefetch (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (pf_load),
    .drain (pf_drain),
    .flush (abort),
    .din   (q_rd_data),
    .dout  (pf_dout),
    .valid (pf_vld)
  );

  assign busy         = (state != S_IDLE);
  assign done         = done_q;
  assign err_update   = err_q;
  assign q_rd_en      = issue;
  assign q_rd_addr    = rd_addr;
  assign data_out     = dout_q;
  assign data_out_vld = vld;

endmodule
